// File: rtl/instr_verify_pipe.sv
// Instruction classifier feeding a small output FIFO, with sticky first-illegal capture and an optional halt.
// Defining VERIFY_STATS_EN adds the saturating illegal_count/total_count statistics ports.
//
// state  | meaning
// RUN    | accepting input whenever the FIFO has room
// HALTED | input blocked after an illegal accept until err_clear; FIFO keeps draining
module instr_verify_pipe #(
    parameter int DEPTH           = 4,
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             out_legal,
    output logic [2:0]       out_class,
    output logic             err_sticky,
    output logic [31:0]      err_instr,
    output logic [31:0]      err_pc,
    input  logic             err_clear
`ifdef VERIFY_STATS_EN
    ,
    output logic [CNT_W-1:0] illegal_count,
    output logic [CNT_W-1:0] total_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_params
        $error("instr_verify_pipe: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc    [DEPTH];
    logic [2:0]  mem_class [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    logic [2:0]  dec_class;
    logic        dec_illegal;

    logic [5:0] opc, fn;
    logic [4:0] rs, rt, rd, sa;
    assign {opc, rs, rt, rd, sa, fn} = in_instr;

    always_comb begin
        dec_class = 3'd7;
        if (in_instr == 32'd0) begin
            dec_class = 3'd0;
        end else begin
            case (opc)
                6'b000000: begin
                    case (fn)
                        6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                        6'b101010, 6'b101011, 6'b000100, 6'b000110, 6'b000111:
                            if (sa == 5'd0) dec_class = 3'd1;
                        6'b000000, 6'b000010, 6'b000011:
                            if (rs == 5'd0) dec_class = 3'd1;
                        6'b011000, 6'b011001, 6'b011010, 6'b011011:
                            if (rd == 5'd0 && sa == 5'd0) dec_class = 3'd1;
                        6'b010000, 6'b010010:
                            if (rs == 5'd0 && rt == 5'd0 && sa == 5'd0) dec_class = 3'd1;
                        6'b010001, 6'b010011:
                            if (rt == 5'd0 && rd == 5'd0 && sa == 5'd0) dec_class = 3'd1;
                        6'b001000:
                            if (rt == 5'd0 && rd == 5'd0 && sa == 5'd0) dec_class = 3'd4;
                        6'b001001:
                            if (rt == 5'd0 && sa == 5'd0) dec_class = 3'd4;
                        default: ;
                    endcase
                end
                6'b001001, 6'b001010, 6'b001011, 6'b001100,
                6'b001101, 6'b001110, 6'b001111: dec_class = 3'd2;
                6'b000010, 6'b000011:            dec_class = 3'd4;
                6'b000100, 6'b000101:            dec_class = 3'd3;
                6'b000110, 6'b000111:            if (rt == 5'd0) dec_class = 3'd3;
                6'b000001:
                    if (rt inside {5'b00000, 5'b00001, 5'b10000, 5'b10001}) dec_class = 3'd3;
                6'b100000, 6'b100001, 6'b100010, 6'b100011,
                6'b100100, 6'b100101, 6'b100110: dec_class = 3'd5;
                6'b101000, 6'b101001, 6'b101011: dec_class = 3'd6;
                default: ;
            endcase
        end
    end

    assign dec_illegal = (dec_class == 3'd7);

    // Extra MSB on the pointers tells full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full && (state == RUN);
    assign push     = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr[AW-1:0]] <= in_instr;
            mem_pc[wr_ptr[AW-1:0]]    <= in_pc;
            mem_class[wr_ptr[AW-1:0]] <= dec_class;
        end
    end

    // Storage is not reset, so outputs are gated to read as zero while empty.
    assign out_instr = out_valid ? mem_instr[rd_ptr[AW-1:0]] : 32'd0;
    assign out_pc    = out_valid ? mem_pc[rd_ptr[AW-1:0]] : 32'd0;
    assign out_class = out_valid ? mem_class[rd_ptr[AW-1:0]] : 3'd0;
    assign out_legal = out_valid && (mem_class[rd_ptr[AW-1:0]] != 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
            err_instr  <= 32'd0;
            err_pc     <= 32'd0;
        end else if (push && dec_illegal && (!err_sticky || err_clear)) begin
            err_sticky <= 1'b1;
            err_instr  <= in_instr;
            err_pc     <= in_pc;
        end else if (err_clear) begin
            err_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (HALT_ON_ILLEGAL && push && dec_illegal) state_nxt = HALTED;
            HALTED:  if (err_clear) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

`ifdef VERIFY_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_count   <= '0;
            illegal_count <= '0;
        end else begin
            if (push && total_count != '1) total_count <= total_count + CNT_W'(1);
            if (push && dec_illegal && illegal_count != '1)
                illegal_count <= illegal_count + CNT_W'(1);
        end
    end
`endif

endmodule
